// File: rtl/perceptron_trainer.sv
// Training sequencer for a perceptron core: replays a stored sample set and issues
// learning-rule weight updates until an epoch is error-free or the epoch limit is hit.
module perceptron_trainer #(
    parameter int unsigned DEPTH       = 8,
    parameter int unsigned RES_LATENCY = 1,
    parameter int unsigned MAX_EPOCHS  = 15
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     wr_en,
    input  logic [7:0]               wr_data,
    input  logic                     wr_label,
    input  logic                     clear,
    input  logic                     start,
    output logic [7:0]               p_in,
    output logic                     p_exp_res,
    input  logic                     p_result,
    output logic                     upd_valid,
    output logic                     upd_inc,
    output logic [7:0]               upd_mask,
    input  logic                     upd_ready,
    output logic                     busy,
    output logic                     done,
    output logic                     converged,
    output logic [3:0]               epoch,
    output logic [$clog2(DEPTH):0]   errors,
    output logic [$clog2(DEPTH):0]   n_samples
);

    localparam int unsigned IdxW  = $clog2(DEPTH);
    localparam int unsigned CntW  = IdxW + 1;
    localparam int unsigned WaitW = (RES_LATENCY > 1) ? $clog2(RES_LATENCY) : 1;

    typedef enum logic [2:0] {
        StIdle,
        StPresent,
        StWait,
        StCheck,
        StUpdate,
        StEpochEnd
    } state_e;

    state_e            state_q, state_d;
    logic [IdxW-1:0]   idx_q, idx_d;
    logic [WaitW-1:0]  wait_q, wait_d;
    logic [3:0]        epoch_q, epoch_d;
    logic [CntW-1:0]   errors_q, errors_d;
    logic [CntW-1:0]   n_samples_q, n_samples_d;
    logic              done_q, done_d;
    logic              converged_q, converged_d;
    logic [7:0]        p_in_q, p_in_d;
    logic              p_exp_res_q, p_exp_res_d;

    logic [7:0]        smp_data_q [DEPTH];
    logic [DEPTH-1:0]  smp_label_q;
    logic              smp_we;

    logic              last_sample;
    logic [3:0]        epoch_inc;

    assign last_sample = ({1'b0, idx_q} == n_samples_q - CntW'(1));
    assign epoch_inc   = (epoch_q == 4'hF) ? epoch_q : epoch_q + 4'd1;

    always_comb begin
        state_d     = state_q;
        idx_d       = idx_q;
        wait_d      = wait_q;
        epoch_d     = epoch_q;
        errors_d    = errors_q;
        n_samples_d = n_samples_q;
        done_d      = done_q;
        converged_d = converged_q;
        p_in_d      = p_in_q;
        p_exp_res_d = p_exp_res_q;
        smp_we      = 1'b0;

        unique case (state_q)
            StIdle: begin
                // start beats clear beats wr_en
                if (start) begin
                    done_d      = 1'b0;
                    converged_d = 1'b0;
                    epoch_d     = '0;
                    errors_d    = '0;
                    idx_d       = '0;
                    if (n_samples_q == '0) begin
                        done_d      = 1'b1;
                        converged_d = 1'b1;
                    end else begin
                        state_d = StPresent;
                    end
                end else if (clear) begin
                    n_samples_d = '0;
                    done_d      = 1'b0;
                    converged_d = 1'b0;
                end else if (wr_en && (n_samples_q < CntW'(DEPTH))) begin
                    smp_we      = 1'b1;
                    n_samples_d = n_samples_q + CntW'(1);
                end
            end
            StPresent: begin
                p_in_d      = smp_data_q[idx_q];
                p_exp_res_d = smp_label_q[idx_q];
                wait_d      = '0;
                state_d     = StWait;
            end
            StWait: begin
                if (wait_q == WaitW'(RES_LATENCY - 1)) begin
                    state_d = StCheck;
                end else begin
                    wait_d = wait_q + WaitW'(1);
                end
            end
            StCheck: begin
                if (p_exp_res_q ^ p_result) begin
                    errors_d = errors_q + CntW'(1);
                    state_d  = StUpdate;
                end else if (last_sample) begin
                    state_d = StEpochEnd;
                end else begin
                    idx_d   = idx_q + IdxW'(1);
                    state_d = StPresent;
                end
            end
            StUpdate: begin
                if (upd_ready) begin
                    if (last_sample) begin
                        state_d = StEpochEnd;
                    end else begin
                        idx_d   = idx_q + IdxW'(1);
                        state_d = StPresent;
                    end
                end
            end
            StEpochEnd: begin
                epoch_d = epoch_inc;
                if (errors_q == '0) begin
                    done_d      = 1'b1;
                    converged_d = 1'b1;
                    state_d     = StIdle;
                end else if (epoch_inc == 4'(MAX_EPOCHS)) begin
                    done_d      = 1'b1;
                    converged_d = 1'b0;
                    state_d     = StIdle;
                end else begin
                    errors_d = '0;
                    idx_d    = '0;
                    state_d  = StPresent;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= StIdle;
            idx_q       <= '0;
            wait_q      <= '0;
            epoch_q     <= '0;
            errors_q    <= '0;
            n_samples_q <= '0;
            done_q      <= 1'b0;
            converged_q <= 1'b0;
            p_in_q      <= '0;
            p_exp_res_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            idx_q       <= idx_d;
            wait_q      <= wait_d;
            epoch_q     <= epoch_d;
            errors_q    <= errors_d;
            n_samples_q <= n_samples_d;
            done_q      <= done_d;
            converged_q <= converged_d;
            p_in_q      <= p_in_d;
            p_exp_res_q <= p_exp_res_d;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < int'(DEPTH); i++) begin
                smp_data_q[i] <= '0;
            end
            smp_label_q <= '0;
        end else if (smp_we) begin
            smp_data_q[n_samples_q[IdxW-1:0]]  <= wr_data;
            smp_label_q[n_samples_q[IdxW-1:0]] <= wr_label;
        end
    end

    assign p_in      = p_in_q;
    assign p_exp_res = p_exp_res_q;
    assign upd_valid = (state_q == StUpdate);
    assign upd_inc   = upd_valid & p_exp_res_q;
    assign upd_mask  = upd_valid ? p_in_q : 8'h00;
    assign busy      = (state_q != StIdle);
    assign done      = done_q;
    assign converged = converged_q;
    assign epoch     = epoch_q;
    assign errors    = errors_q;
    assign n_samples = n_samples_q;

endmodule

// File: tb/tb_perceptron_trainer.sv
// Scoreboard bench for perceptron_trainer: a behavioural perceptron stub answers samples,
// expected updates and run results are queued at stimulus time and popped by a monitor.
module tb_perceptron_trainer;

    logic       clk = 1'b0;
    logic       reset, wr_en, wr_label, clear, start, p_result, upd_ready;
    logic [7:0] wr_data, p_in, upd_mask;
    logic       p_exp_res, upd_valid, upd_inc, busy, done, converged;
    logic [3:0] epoch, errors, n_samples;

    int total = 0;
    int bad   = 0;

    typedef struct packed {logic inc; logic [7:0] mask;} upd_t;
    typedef struct packed {logic [3:0] epoch; logic conv; logic [3:0] errors;} res_t;
    upd_t upd_q[$];
    res_t res_q[$];
    upd_t ue;
    res_t re;
    logic done_prev = 1'b0;

    // Perceptron stub: 0 always correct, 1 outputs 0 until first update, 2 always wrong on 8'h01
    int   mode = 0;
    logic learned = 1'b0;

    always #5 clk = ~clk;

    perceptron_trainer dut (
        .clk       (clk),
        .reset     (reset),
        .wr_en     (wr_en),
        .wr_data   (wr_data),
        .wr_label  (wr_label),
        .clear     (clear),
        .start     (start),
        .p_in      (p_in),
        .p_exp_res (p_exp_res),
        .p_result  (p_result),
        .upd_valid (upd_valid),
        .upd_inc   (upd_inc),
        .upd_mask  (upd_mask),
        .upd_ready (upd_ready),
        .busy      (busy),
        .done      (done),
        .converged (converged),
        .epoch     (epoch),
        .errors    (errors),
        .n_samples (n_samples)
    );

    always @(posedge clk) begin
        learned <= (mode == 1) ? (learned | (upd_valid & upd_ready)) : 1'b0;
        case (mode)
            0:       p_result <= p_exp_res;
            1:       p_result <= learned ? p_exp_res : 1'b0;
            default: p_result <= (p_in == 8'h01) ? ~p_exp_res : p_exp_res;
        endcase
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    always @(negedge clk) begin
        if (upd_valid && upd_ready) begin
            if (upd_q.size() == 0) begin
                check("upd_unexpected", upd_q.size(), 1);
            end else begin
                ue = upd_q.pop_front();
                check("upd_inc", upd_inc, ue.inc);
                check("upd_mask", upd_mask, ue.mask);
            end
        end
        if (done && !done_prev) begin
            if (res_q.size() == 0) begin
                check("done_unexpected", res_q.size(), 1);
            end else begin
                re = res_q.pop_front();
                check("res_epoch", epoch, re.epoch);
                check("res_converged", converged, re.conv);
                check("res_errors", errors, re.errors);
            end
        end
        done_prev = done;
    end

    task automatic write(input logic [7:0] d, input logic l);
        wr_en = 1'b1; wr_data = d; wr_label = l;
        @(posedge clk); #1;
        wr_en = 1'b0;
    endtask

    task automatic pulse_start();
        start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
    endtask

    task automatic pulse_clear();
        clear = 1'b1;
        @(posedge clk); #1;
        clear = 1'b0;
    endtask

    task automatic wait_done(input string name);
        for (int i = 0; i < 3000; i++) begin
            if (done && !busy) break;
            @(posedge clk); #1;
        end
        check(name, done, 1);
        @(negedge clk); #1;
    endtask

    task automatic wait_upd(input string name);
        for (int i = 0; i < 200; i++) begin
            if (upd_valid) break;
            @(posedge clk); #1;
        end
        check(name, upd_valid, 1);
    endtask

    initial begin
        reset = 1'b1; wr_en = 1'b0; wr_data = '0; wr_label = 1'b0;
        clear = 1'b0; start = 1'b0; upd_ready = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        check("rst_busy", busy, 0);
        check("rst_done", done, 0);
        check("rst_conv", converged, 0);
        check("rst_epoch", epoch, 0);
        check("rst_errors", errors, 0);
        check("rst_n", n_samples, 0);
        check("rst_upd_valid", upd_valid, 0);
        check("rst_p_in", p_in, 0);
        reset = 1'b0;
        @(posedge clk); #1;

        // All samples classified correctly: one clean epoch, no updates
        mode = 0;
        write(8'h11, 1'b1);
        write(8'h22, 1'b0);
        write(8'h33, 1'b1);
        write(8'h44, 1'b0);
        check("t1_n", n_samples, 4);
        res_q.push_back('{epoch: 4'd1, conv: 1'b1, errors: 4'd0});
        pulse_start();
        check("t1_busy", busy, 1);
        wait_done("t1_done");
        check("t1_upd_left", upd_q.size(), 0);
        check("t1_res_left", res_q.size(), 0);

        // One miss in epoch 1, clean epoch 2
        pulse_clear();
        check("t2_clear_n", n_samples, 0);
        check("t2_clear_done", done, 0);
        write(8'h01, 1'b1);
        write(8'h02, 1'b0);
        mode = 1;
        upd_q.push_back('{inc: 1'b1, mask: 8'h01});
        res_q.push_back('{epoch: 4'd2, conv: 1'b1, errors: 4'd0});
        pulse_start();
        wait_done("t2_done");
        check("t2_upd_left", upd_q.size(), 0);
        check("t2_res_left", res_q.size(), 0);

        // Never learns sample 0: gives up at epoch 15 after 15 updates
        mode = 2;
        for (int i = 0; i < 15; i++) upd_q.push_back('{inc: 1'b1, mask: 8'h01});
        res_q.push_back('{epoch: 4'd15, conv: 1'b0, errors: 4'd1});
        pulse_start();
        wait_done("t3_done");
        check("t3_upd_left", upd_q.size(), 0);
        check("t3_res_left", res_q.size(), 0);

        // Back-pressure: update held stable, no new sample presented while stalled
        mode = 1;
        @(posedge clk); #1;
        upd_ready = 1'b0;
        upd_q.push_back('{inc: 1'b1, mask: 8'h01});
        res_q.push_back('{epoch: 4'd2, conv: 1'b1, errors: 4'd0});
        pulse_start();
        wait_upd("t4_upd_seen");
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            check("t4_valid", upd_valid, 1);
            check("t4_inc", upd_inc, 1);
            check("t4_mask", upd_mask, 8'h01);
            check("t4_p_in", p_in, 8'h01);
        end
        @(posedge clk); #1;
        upd_ready = 1'b1;
        wait_done("t4_done");
        check("t4_upd_left", upd_q.size(), 0);
        check("t4_res_left", res_q.size(), 0);

        // Full buffer drops the ninth write; empty start finishes immediately
        reset = 1'b1;
        @(posedge clk); #1;
        reset = 1'b0;
        for (int i = 0; i < 9; i++) write(8'(i + 1), 1'b0);
        check("t5_n_full", n_samples, 8);
        pulse_clear();
        check("t5_n_clear", n_samples, 0);
        res_q.push_back('{epoch: 4'd0, conv: 1'b1, errors: 4'd0});
        pulse_start();
        check("t5_empty_done", done, 1);
        check("t5_empty_busy", busy, 0);
        @(negedge clk); #1;
        check("t5_res_left", res_q.size(), 0);

        // Reset while an update is pending
        write(8'h01, 1'b1);
        write(8'h02, 1'b0);
        mode = 2;
        upd_ready = 1'b0;
        pulse_start();
        wait_upd("t6_upd_seen");
        reset = 1'b1;
        @(posedge clk); #1;
        check("t6_busy", busy, 0);
        check("t6_upd_valid", upd_valid, 0);
        check("t6_n", n_samples, 0);
        check("t6_done", done, 0);
        reset = 1'b0;
        upd_ready = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        check("t6_idle_busy", busy, 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
